// File: rtl/wb_test_status.sv
// wb_test_status: Wishbone-mapped test-status reporter for the user project area.
// Firmware writes a 5-bit stage and an error flag, which are driven as {error, stage}
// onto mprj_io[37:32]. An optional hardware watchdog flags an error when firmware stops
// making progress; it is built only when WB_TEST_STATUS_WDOG_EN is defined.
module wb_test_status #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WDOG_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [5:0]  status_o,
  output logic [5:0]  status_oeb
);

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_LOAD   = 4'h8;
  localparam logic [3:0] OFF_INFO   = 4'hC;
  localparam logic [4:0] STAGE_PASS = 5'd30;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_SW   = 2'd1;
  localparam logic [1:0] CAUSE_WDOG = 2'd2;
  localparam logic [1:0] CAUSE_LOCK = 2'd3;

  typedef enum logic {ST_RUN, ST_PASSED} state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [4:0]  stage_q, stage_d;
  logic        error_q, error_d;
  logic [1:0]  cause_q, cause_d;
  logic        out_en_q, out_en_d;
  logic [5:0]  status_q, status_d;

  logic        hit, access, wr, status_wr, ctrl_wr, clr_req, passed, expire;
  logic [3:0]  off;
  logic [1:0]  new_cause;
  logic [31:0] rd_data;
  logic              wdog_en_rd;
  logic [WDOG_W-1:0] load_rd, count_rd;

  // Write data and byte selects are only partly used, depending on the build.
  logic unused_inputs;
  assign unused_inputs = ^{wbs_dat_i, wbs_sel_i};

  assign off       = wbs_adr_i[3:0];
  assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access    = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
  assign wr        = access & wbs_we_i;
  assign status_wr = wr & (off == OFF_STATUS) & wbs_sel_i[0];
  assign ctrl_wr   = wr & (off == OFF_CTRL) & wbs_sel_i[0];
  assign clr_req   = ctrl_wr & wbs_dat_i[2];
  assign passed    = (state_q == ST_PASSED);

`ifdef WB_TEST_STATUS_WDOG_EN
  logic              wdog_en_q, wdog_en_d;
  logic [WDOG_W-1:0] load_q, load_d;
  logic [WDOG_W-1:0] count_q, count_d;
  logic              load_wr, dec;

  assign load_wr    = wr & (off == OFF_LOAD);
  assign wdog_en_rd = wdog_en_q;
  assign load_rd    = load_q;
  assign count_rd   = count_q;

  // Watchdog: reload on enable edge or kick, otherwise count down while armed.
  always_comb begin
    wdog_en_d = wdog_en_q;
    load_d    = load_q;
    count_d   = count_q;
    dec       = wdog_en_q && (count_q != '0) && !error_q && !passed;
    expire    = dec && (count_q == WDOG_W'(1));
    if (ctrl_wr) wdog_en_d = wbs_dat_i[1];
    if (load_wr) begin
      for (int i = 0; i < WDOG_W; i++) begin
        if (wbs_sel_i[i/8]) load_d[i] = wbs_dat_i[i];
      end
    end
    if (ctrl_wr && wbs_dat_i[1] && !wdog_en_q) count_d = load_q;
    else if (status_wr && wdog_en_q)           count_d = load_q;
    else if (dec)                              count_d = count_q - WDOG_W'(1);
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_en_q <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
    end else begin
      wdog_en_q <= wdog_en_d;
      load_q    <= load_d;
      count_q   <= count_d;
    end
  end
`else
  assign expire     = 1'b0;
  assign wdog_en_rd = 1'b0;
  assign load_rd    = '0;
  assign count_rd   = '0;
`endif

  // Register read mux; unmapped offsets inside the window read as zero.
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_STATUS: rd_data[5:0] = {error_q, stage_q};
      OFF_CTRL:   rd_data[1:0] = {wdog_en_rd, out_en_q};
      OFF_LOAD:   rd_data[WDOG_W-1:0] = load_rd;
      OFF_INFO: begin
        rd_data[31:30]       = cause_q;
        rd_data[29]          = passed;
        rd_data[WDOG_W-1:0]  = count_rd;
      end
      default: rd_data = '0;
    endcase
  end

  // Bus response: single-cycle ack, read data only alongside a read ack.
  always_comb begin
    ack_d = access;
    dat_d = (access && !wbs_we_i) ? rd_data : '0;
  end

  // Stage FSM, sticky error with first-cause latching, and control bits.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    error_d   = error_q;
    cause_d   = cause_q;
    out_en_d  = out_en_q;
    new_cause = CAUSE_NONE;

    // Expiry outranks a coincident STATUS write as the recorded cause.
    if (expire)                        new_cause = CAUSE_WDOG;
    else if (status_wr && passed)      new_cause = CAUSE_LOCK;
    else if (status_wr && wbs_dat_i[5]) new_cause = CAUSE_SW;

    if (new_cause != CAUSE_NONE) begin
      if (!error_q) begin
        error_d = 1'b1;
        cause_d = new_cause;
      end
    end else if (clr_req && !passed) begin
      error_d = 1'b0;
      cause_d = CAUSE_NONE;
    end

    if (status_wr && !passed) stage_d = wbs_dat_i[4:0];

    if (state_q == ST_RUN && status_wr && wbs_dat_i[4:0] == STAGE_PASS &&
        !wbs_dat_i[5] && !error_q && !expire)
      state_d = ST_PASSED;

    if (ctrl_wr) out_en_d = wbs_dat_i[0];

    status_d = {error_q, stage_q};
  end

  // Core state registers; reset also drops any pending ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      stage_q  <= '0;
      error_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
      out_en_q <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      stage_q  <= stage_d;
      error_q  <= error_d;
      cause_q  <= cause_d;
      out_en_q <= out_en_d;
      status_q <= status_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign status_o   = status_q;
  assign status_oeb = out_en_q ? 6'h00 : 6'h3F;

endmodule
